dataflow_regbank: RTL
=====================

Name: dataflow_regbank

Overview:
- Parametrised successor of the fixed 8-bit CPU internal datapath.
- Provides NUM_REGS general registers, NUM_BUSES internal buses joined by a chain of bridge switches, and a PC_WIDTH program counter with inc/dec/load.
- Adds a registered data-output port with valid/ready handshake.
- Micro-ops are issued by the control logic through a valid/ready handshake. The block stalls on missing external read data or a full output register.
- Buses are modelled as precharged: an undriven bus reads all-ones; multiple drivers combine by wired-AND and raise a sticky contention error.

Parameters:
- DATA_WIDTH, 8: width of every bus and register.
- NUM_REGS, 8: number of general registers (>=1).
- NUM_BUSES, 3: number of internal buses (>=2).
- PC_WIDTH, 16: program counter width; must equal 2*DATA_WIDTH.
- SAT_WIDTH, 16: width of the stall counter.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- uop_valid  in  1  micro-op present.
- uop_ready  out  1  micro-op accepted this cycle when high with uop_valid.
- uop_src  in  NUM_BUSES*SRC_W  per-bus source select; SRC_W=$clog2(NUM_REGS+4).
- uop_bridge  in  NUM_BUSES-1  bit k closes the switch between bus k and bus k+1.
- uop_ld_en  in  NUM_REGS  per-register load enable.
- uop_ld_bus  in  NUM_REGS*BUS_W  bus index each register loads from; BUS_W=$clog2(NUM_BUSES).
- uop_pc_op  in  2  PC operation: hold/inc/dec/load.
- uop_dor_ld  in  1  load the output register.
- uop_dor_bus  in  BUS_W  bus index the output register loads from.
- ext_rdata  in  DATA_WIDTH  external read data.
- ext_rvalid  in  1  ext_rdata valid.
- ext_wdata  out  DATA_WIDTH  output register contents.
- ext_wvalid  out  1  ext_wdata pending.
- ext_wready  in  1  consumer accepts ext_wdata.
- err_clr  in  1  clears err_contention.
- err_contention  out  1  sticky contention flag.
- stall_cnt  out  SAT_WIDTH  saturating count of stalled cycles.
- pc  out  PC_WIDTH  program counter.
- reg_dbg  out  NUM_REGS*DATA_WIDTH  all register values.

Behaviour:
- Reset (nrst low, asynchronous): all registers, pc, ext_wdata, stall_cnt clear to 0; ext_wvalid=0; err_contention=0.
- Source encoding per bus:
  - 0: none.
  - 1..NUM_REGS: register (index-1).
  - NUM_REGS+1: ext_rdata.
  - NUM_REGS+2: pc low byte.
  - NUM_REGS+3: pc high byte.
  - Any other code: none.
- Bus resolution (combinational):
  - Closed bridges partition the buses into connected groups.
  - Every bus in a group carries the AND of all driven values in that group.
  - A group with no driver reads all-ones.
  - A group with 2 or more drivers is contention.
- Handshake:
  - uop_ready=0 when some bus selects ext_rdata and ext_rvalid=0.
  - uop_ready=0 when uop_dor_ld=1, ext_wvalid=1 and ext_wready=0.
  - Otherwise uop_ready=1.
  - uop_ready depends on the uop fields and state, never on uop_valid.
- Execution:
  - A uop takes effect only on fire (uop_valid & uop_ready).
  - Every update lands on the clk edge ending the fire cycle, so latency is 1 cycle.
  - Register reads return pre-edge values, so a swap through buses in one uop is legal.
- PC operations:
  - 00: hold.
  - 01: +1, wrapping FFFF->0000.
  - 10: -1, wrapping 0000->FFFF.
  - 11: load {bus NUM_BUSES-1, bus 0} (high byte, low byte).
  - Loaded values take effect with no increment.
- Output register, two states EMPTY/FULL:
  - EMPTY, dor_ld fire: load and go FULL.
  - FULL, ext_wready=1 with no dor_ld fire: go EMPTY.
  - FULL, ext_wready=1 with dor_ld fire in the same cycle: reload and stay FULL (back-to-back, no bubble).
- err_contention:
  - Set on a fire cycle with any contended group.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Contention on non-fire cycles is ignored.
- stall_cnt:
  - Increments on uop_valid & ~uop_ready.
  - Saturates at all-ones.
- Reset mid-stall drops the pending uop; the issuer must re-present it.

Decomposition:
- Shared package dataflow_pkg holds:
  - The source-code localparams (SRC_NONE, SRC_EXT, SRC_PCL, SRC_PCH offsets from NUM_REGS).
  - The pc_op_t enum {PC_HOLD, PC_INC, PC_DEC, PC_LOAD}.
  - The dor_state_t enum {DOR_EMPTY, DOR_FULL}.
- Sub-module bus_resolver: parametrised by NUM_BUSES and DATA_WIDTH. Takes per-bus driven flags, values and the bridge mask; returns resolved buses and the contention flag. It is purely combinational and reused by the future wide-bus variant.

Test Plan:
- Reset, then uop with src bus0=ext (ext_rdata=0x5A, ext_rvalid=1), ld_en reg2 from bus0 -> reg2=0x5A next cycle; all other registers 0.
- No driver on bus1, ld reg3 from bus1 -> reg3=0xFF; bridge0 closed, bus0=reg2 (0x5A) and bus1=ext 0x0F -> both buses 0x0A, err_contention=1; err_clr with no contention -> 0.
- ext_rvalid=0 for 3 cycles with an ext-sourcing uop -> uop_ready=0, stall_cnt=3, no state change; rvalid=1 -> fire.
- pc=0xFFFF with inc -> 0x0000; dec -> 0xFFFF; load with bus0=0x34, bus2=0x12 -> pc=0x1234.
- dor_ld of 0xAA with ext_wready=0 -> ext_wvalid=1; a second dor_ld stalls; ext_wready=1 -> 0xAA consumed and next value loaded same cycle, ext_wvalid stays 1.
- Swap: reg0=1, reg1=2; bus0=reg0, bus1=reg1, reg0 loads bus1, reg1 loads bus0 -> reg0=2, reg1=1.

Source files
------------

// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow register bank: bus source codes,
// program counter operations and output register states.
package dataflow_pkg;

  // Source codes above the register range are offsets from NUM_REGS
  localparam int SRC_NONE    = 0;
  localparam int SRC_EXT_OFS = 1;
  localparam int SRC_PCL_OFS = 2;
  localparam int SRC_PCH_OFS = 3;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_DEC  = 2'b10,
    PC_LOAD = 2'b11
  } pc_op_t;

  typedef enum logic {
    DOR_EMPTY = 1'b0,
    DOR_FULL  = 1'b1
  } dor_state_t;

endpackage

// File: rtl/dataflow_bus_resolver.sv
// Precharged bus model: closed bridges join neighbouring buses into groups,
// every bus in a group carries the wired-AND of its group's drivers, an
// undriven group reads all-ones and two or more drivers in a group flag
// contention. Purely combinational.
module bus_resolver #(
  parameter int NUM_BUSES  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic [NUM_BUSES-1:0]            drv,
  input  logic [NUM_BUSES*DATA_WIDTH-1:0] val,
  input  logic [NUM_BUSES-2:0]            bridge,
  output logic [NUM_BUSES*DATA_WIDTH-1:0] bus,
  output logic                            contention
);

  localparam int GW = $clog2(NUM_BUSES);

  logic [GW-1:0]        grp [NUM_BUSES];
  logic [NUM_BUSES-1:0] multi;

  // Label each bus with a group id; an open bridge starts a new group
  always_comb begin
    logic [GW-1:0] cur;
    cur    = '0;
    grp[0] = '0;
    for (int i = 1; i < NUM_BUSES; i++) begin
      if (!bridge[i-1]) begin
        cur = cur + GW'(1);
      end
      grp[i] = cur;
    end
  end

  // Wired-AND all drivers sharing a bus's group and note multiple drivers
  always_comb begin
    logic [DATA_WIDTH-1:0] acc;
    logic                  seen;
    logic                  dup;
    bus   = '1;
    multi = '0;
    acc   = '1;
    seen  = 1'b0;
    dup   = 1'b0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      acc  = '1;
      seen = 1'b0;
      dup  = 1'b0;
      for (int j = 0; j < NUM_BUSES; j++) begin
        if (drv[j] && (grp[j] == grp[i])) begin
          if (seen) begin
            dup = 1'b1;
          end
          seen = 1'b1;
          acc  = acc & val[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      bus[i*DATA_WIDTH +: DATA_WIDTH] = acc;
      multi[i] = dup;
    end
  end

  assign contention = |multi;

endmodule

// File: rtl/dataflow_regbank.sv
// CPU internal datapath: general registers, bridged internal buses, program
// counter and a handshaked output register, driven by micro-ops that fire on
// uop_valid & uop_ready. All updates land on the edge ending the fire cycle.
module dataflow_regbank
  import dataflow_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int NUM_BUSES  = 3,
  parameter int PC_WIDTH   = 16,
  parameter int SAT_WIDTH  = 16,
  localparam int SRC_W     = $clog2(NUM_REGS + 4),
  localparam int BUS_W     = $clog2(NUM_BUSES)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           uop_valid,
  output logic                           uop_ready,
  input  logic [NUM_BUSES*SRC_W-1:0]     uop_src,
  input  logic [NUM_BUSES-2:0]           uop_bridge,
  input  logic [NUM_REGS-1:0]            uop_ld_en,
  input  logic [NUM_REGS*BUS_W-1:0]      uop_ld_bus,
  input  logic [1:0]                     uop_pc_op,
  input  logic                           uop_dor_ld,
  input  logic [BUS_W-1:0]               uop_dor_bus,
  input  logic [DATA_WIDTH-1:0]          ext_rdata,
  input  logic                           ext_rvalid,
  output logic [DATA_WIDTH-1:0]          ext_wdata,
  output logic                           ext_wvalid,
  input  logic                           ext_wready,
  input  logic                           err_clr,
  output logic                           err_contention,
  output logic [SAT_WIDTH-1:0]           stall_cnt,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_dbg
);

  localparam logic [SRC_W-1:0] CODE_NONE = SRC_W'(SRC_NONE);
  localparam logic [SRC_W-1:0] CODE_EXT  = SRC_W'(NUM_REGS + SRC_EXT_OFS);
  localparam logic [SRC_W-1:0] CODE_PCL  = SRC_W'(NUM_REGS + SRC_PCL_OFS);
  localparam logic [SRC_W-1:0] CODE_PCH  = SRC_W'(NUM_REGS + SRC_PCH_OFS);

  logic [DATA_WIDTH-1:0]           regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]           regs_d [NUM_REGS];
  logic [PC_WIDTH-1:0]             pc_q, pc_d;
  logic [DATA_WIDTH-1:0]           dor_data_q, dor_data_d;
  dor_state_t                      dor_state_q, dor_state_d;
  logic                            err_q, err_d;
  logic [SAT_WIDTH-1:0]            stall_q, stall_d;

  logic [NUM_BUSES-1:0]            drv;
  logic [NUM_BUSES*DATA_WIDTH-1:0] drv_val;
  logic [NUM_BUSES*DATA_WIDTH-1:0] bus_flat;
  logic                            contention;
  logic                            need_ext;
  logic                            ext_stall;
  logic                            dor_stall;
  logic                            fire;

  // Out-of-range bus indices see an undriven (all-ones) bus
  function automatic logic [DATA_WIDTH-1:0] pick_bus(
    input logic [BUS_W-1:0]                idx,
    input logic [NUM_BUSES*DATA_WIDTH-1:0] buses
  );
    logic [DATA_WIDTH-1:0] res;
    res = '1;
    for (int b = 0; b < NUM_BUSES; b++) begin
      if (idx == BUS_W'(b)) begin
        res = buses[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return res;
  endfunction

  // Decode each bus's source select into a driven flag and driven value
  always_comb begin
    logic [SRC_W-1:0] src;
    drv      = '0;
    drv_val  = '1;
    need_ext = 1'b0;
    src      = '0;
    for (int b = 0; b < NUM_BUSES; b++) begin
      src = uop_src[b*SRC_W +: SRC_W];
      if (src != CODE_NONE) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (src == SRC_W'(r + 1)) begin
            drv[b] = 1'b1;
            drv_val[b*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
          end
        end
        if (src == CODE_EXT) begin
          drv[b]   = 1'b1;
          need_ext = 1'b1;
          drv_val[b*DATA_WIDTH +: DATA_WIDTH] = ext_rdata;
        end
        if (src == CODE_PCL) begin
          drv[b] = 1'b1;
          drv_val[b*DATA_WIDTH +: DATA_WIDTH] = pc_q[DATA_WIDTH-1:0];
        end
        if (src == CODE_PCH) begin
          drv[b] = 1'b1;
          drv_val[b*DATA_WIDTH +: DATA_WIDTH] = pc_q[PC_WIDTH-1 -: DATA_WIDTH];
        end
      end
    end
  end

  bus_resolver #(
    .NUM_BUSES  (NUM_BUSES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus_resolver (
    .drv        (drv),
    .val        (drv_val),
    .bridge     (uop_bridge),
    .bus        (bus_flat),
    .contention (contention)
  );

  assign ext_stall = need_ext & ~ext_rvalid;
  assign dor_stall = uop_dor_ld & (dor_state_q == DOR_FULL) & ~ext_wready;
  assign uop_ready = ~(ext_stall | dor_stall);
  assign fire      = uop_valid & uop_ready;

  // Register file and program counter updates on a firing micro-op
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    pc_d = pc_q;
    if (fire) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (uop_ld_en[r]) begin
          regs_d[r] = pick_bus(uop_ld_bus[r*BUS_W +: BUS_W], bus_flat);
        end
      end
      case (pc_op_t'(uop_pc_op))
        PC_INC:  pc_d = pc_q + PC_WIDTH'(1);
        PC_DEC:  pc_d = pc_q - PC_WIDTH'(1);
        PC_LOAD: pc_d = {bus_flat[(NUM_BUSES-1)*DATA_WIDTH +: DATA_WIDTH],
                         bus_flat[0 +: DATA_WIDTH]};
        default: pc_d = pc_q;
      endcase
    end
  end

  // Output register: a firing load wins over the consumer draining it
  always_comb begin
    dor_state_d = dor_state_q;
    dor_data_d  = dor_data_q;
    if (fire && uop_dor_ld) begin
      dor_data_d  = pick_bus(uop_dor_bus, bus_flat);
      dor_state_d = DOR_FULL;
    end else if ((dor_state_q == DOR_FULL) && ext_wready) begin
      dor_state_d = DOR_EMPTY;
    end
  end

  // Sticky contention flag (set beats clear) and saturating stall counter
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (fire && contention) begin
      err_d = 1'b1;
    end
    stall_d = stall_q;
    if (uop_valid && !uop_ready && (stall_q != '1)) begin
      stall_d = stall_q + SAT_WIDTH'(1);
    end
  end

  // State flops with asynchronous clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      pc_q        <= '0;
      dor_data_q  <= '0;
      dor_state_q <= DOR_EMPTY;
      err_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pc_q        <= pc_d;
      dor_data_q  <= dor_data_d;
      dor_state_q <= dor_state_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

  // Flatten the register file for observation
  always_comb begin
    reg_dbg = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_dbg[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
    end
  end

  assign ext_wdata      = dor_data_q;
  assign ext_wvalid     = (dor_state_q == DOR_FULL);
  assign err_contention = err_q;
  assign stall_cnt      = stall_q;
  assign pc             = pc_q;

endmodule
